// File: rtl/cp0_exc_timer.sv
// -----------------------------------------------------------------------------
// cp0_exc_timer
//
// CP0 exception / timer unit for the writeback stage. Holds BadVAddr, Count,
// Compare, Status, Cause and EPC, provides a prescaled Count/Compare timer
// interrupt and samples up to six external interrupt lines into Cause.IP.
//
// Parameters:
//   EXT_INT_NUM  number of hardware interrupt lines (1..6), ext_int[i] -> IP[2+i]
//   COUNT_DIV    clock cycles per Count increment (>= 1)
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   cp0_addr        {rd[4:0], sel[2:0]} register select for MFC0/MTC0
//   cp0_wen         MTC0 write strobe (already qualified by ws_valid)
//   cp0_wdata       MTC0 write data
//   cp0_rdata       MFC0 read data, combinational from register state
//   exc_valid       exception commits this cycle
//   exc_code        ExcCode of the committing exception
//   exc_pc          PC of the excepting instruction
//   exc_bd          excepting instruction sits in a delay slot
//   exc_badv_valid  load BadVAddr with exc_badvaddr on this exception
//   exc_badvaddr    faulting virtual address
//   eret            ERET commits this cycle
//   ext_int         external interrupt levels
//   int_pending     interrupt request to the pipeline
//   epc             current EPC
//   status_exl      current Status.EXL
// -----------------------------------------------------------------------------
module cp0_exc_timer #(
   parameter int unsigned EXT_INT_NUM = 6,
   parameter int unsigned COUNT_DIV   = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             cp0_addr,
   input  logic                   cp0_wen,
   input  logic [31:0]            cp0_wdata,
   output logic [31:0]            cp0_rdata,
   input  logic                   exc_valid,
   input  logic [4:0]             exc_code,
   input  logic [31:0]            exc_pc,
   input  logic                   exc_bd,
   input  logic                   exc_badv_valid,
   input  logic [31:0]            exc_badvaddr,
   input  logic                   eret,
   input  logic [EXT_INT_NUM-1:0] ext_int,
   output logic                   int_pending,
   output logic [31:0]            epc,
   output logic                   status_exl
);

   localparam logic [7:0] ADDR_BADVADDR = {5'd8,  3'd0};
   localparam logic [7:0] ADDR_COUNT    = {5'd9,  3'd0};
   localparam logic [7:0] ADDR_COMPARE  = {5'd11, 3'd0};
   localparam logic [7:0] ADDR_STATUS   = {5'd12, 3'd0};
   localparam logic [7:0] ADDR_CAUSE    = {5'd13, 3'd0};
   localparam logic [7:0] ADDR_EPC      = {5'd14, 3'd0};

   // A one-bit prescaler is kept even for COUNT_DIV=1; it then sits at 0 and
   // wraps every cycle.
   localparam int unsigned   PW         = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

   // Architectural state
   logic [31:0]   badvaddr_q;
   logic [31:0]   count_q;
   logic [31:0]   compare_q;
   logic [31:0]   epc_q;
   logic [7:0]    im_q;
   logic          exl_q;
   logic          ie_q;
   logic          bd_q;
   logic          ti_q;
   logic [5:0]    ip_hw_q;      // Cause.IP[7:2] as sampled from ext_int
   logic [1:0]    ip_sw_q;      // Cause.IP[1:0], software interrupts
   logic [4:0]    exccode_q;
   logic [PW-1:0] presc_q;
   logic          count_inc_q;  // Count was advanced by the timer last cycle

   // Derived signals
   logic          mtc0;
   logic          wr_count;
   logic          wr_compare;
   logic          wr_status;
   logic          wr_cause;
   logic          wr_epc;
   logic          presc_wrap;
   logic [5:0]    ext_lines;
   logic [7:0]    ip_full;
   logic [31:0]   status_word;
   logic [31:0]   cause_word;

   // A committing exception or ERET flushes the MTC0 in WB, so its write is dropped.
   assign mtc0       = cp0_wen & ~exc_valid & ~eret;
   assign wr_count   = mtc0 & (cp0_addr == ADDR_COUNT);
   assign wr_compare = mtc0 & (cp0_addr == ADDR_COMPARE);
   assign wr_status  = mtc0 & (cp0_addr == ADDR_STATUS);
   assign wr_cause   = mtc0 & (cp0_addr == ADDR_CAUSE);
   assign wr_epc     = mtc0 & (cp0_addr == ADDR_EPC);

   assign presc_wrap = (presc_q == PRESC_LAST);

   // Lines beyond EXT_INT_NUM are tied low.
   always_comb begin
      ext_lines = '0;
      ext_lines[EXT_INT_NUM-1:0] = ext_int;
   end

   // Timer interrupt shares IP[7] with the sixth external line.
   assign ip_full     = {ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q};
   assign status_word = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
   assign cause_word  = {bd_q, ti_q, 14'd0, ip_full, 1'b0, exccode_q, 2'b00};

   // ---------------------------------------------------------------------------
   // Count and prescaler
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q     <= '0;
         count_q     <= '0;
         count_inc_q <= 1'b0;
      end else if (wr_count) begin
         presc_q     <= '0;
         count_q     <= cp0_wdata;
         count_inc_q <= 1'b0;
      end else begin
         count_inc_q <= presc_wrap;
         if (presc_wrap) begin
            presc_q <= '0;
            count_q <= count_q + 32'd1;
         end else begin
            presc_q <= presc_q + PW'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Compare and timer interrupt
   // ---------------------------------------------------------------------------
   // TI is raised one cycle after a timer-driven Count step lands on Compare;
   // a Count load never raises it, and a Compare write clears it even if the
   // match would fire in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         compare_q <= '0;
         ti_q      <= 1'b0;
      end else if (wr_compare) begin
         compare_q <= cp0_wdata;
         ti_q      <= 1'b0;
      end else if (count_inc_q && (count_q == compare_q)) begin
         ti_q      <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Interrupt pending bits
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ip_hw_q <= '0;
         ip_sw_q <= '0;
      end else begin
         ip_hw_q <= ext_lines;
         if (wr_cause) begin
            ip_sw_q <= cp0_wdata[9:8];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Exception / ERET / MTC0 on Status, EPC, Cause.BD/ExcCode, BadVAddr
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         epc_q      <= '0;
         bd_q       <= 1'b0;
         exccode_q  <= '0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         im_q       <= '0;
         badvaddr_q <= '0;
      end else if (exc_valid) begin
         // A nested exception (EXL already set) keeps the original return point.
         if (!exl_q) begin
            epc_q <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
            bd_q  <= exc_bd;
         end
         exccode_q <= exc_code;
         exl_q     <= 1'b1;
         if (exc_badv_valid) begin
            badvaddr_q <= exc_badvaddr;
         end
      end else if (eret) begin
         exl_q <= 1'b0;
      end else begin
         if (wr_status) begin
            im_q  <= cp0_wdata[15:8];
            exl_q <= cp0_wdata[1];
            ie_q  <= cp0_wdata[0];
         end
         if (wr_epc) begin
            epc_q <= cp0_wdata;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // MFC0 read mux
   // ---------------------------------------------------------------------------
   always_comb begin
      cp0_rdata = '0;
      case (cp0_addr)
         ADDR_BADVADDR: cp0_rdata = badvaddr_q;
         ADDR_COUNT:    cp0_rdata = count_q;
         ADDR_COMPARE:  cp0_rdata = compare_q;
         ADDR_STATUS:   cp0_rdata = status_word;
         ADDR_CAUSE:    cp0_rdata = cause_word;
         ADDR_EPC:      cp0_rdata = epc_q;
         default:       cp0_rdata = '0;
      endcase
   end

   assign int_pending = ie_q & ~exl_q & (|(ip_full & im_q));
   assign epc         = epc_q;
   assign status_exl  = exl_q;

endmodule

// File: doc/cp0_exc_timer.md
Name: cp0_exc_timer

Overview:
Parameterised CP0 exception/timer unit for the writeback stage; successor to the fixed CP0 register file.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC.
- Adds a Count/Compare timer interrupt with a configurable Count prescaler.
- Supports a configurable number of external interrupt lines.
- Defines exception, ERET and MTC0 interaction rules for the WB stage.

Parameters:
EXT_INT_NUM, 6, number of hardware interrupt lines (1..6); mapped to Cause.IP[2+i].
COUNT_DIV, 2, clock cycles per Count increment (>=1).

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
cp0_addr  input  8  {rd[4:0], sel[2:0]} register select
cp0_wen  input  1  MTC0 write strobe (already qualified by ws_valid)
cp0_wdata  input  32  MTC0 write data
cp0_rdata  output  32  MFC0 read data, combinational
exc_valid  input  1  exception commit this cycle
exc_code  input  5  ExcCode of committing exception
exc_pc  input  32  PC of excepting instruction
exc_bd  input  1  excepting instruction is in a delay slot
exc_badv_valid  input  1  load BadVAddr this exception
exc_badvaddr  input  32  faulting virtual address
eret  input  1  ERET commit this cycle
ext_int  input  EXT_INT_NUM  external interrupt levels
int_pending  output  1  interrupt request to the pipeline
epc  output  32  current EPC
status_exl  output  1  current Status.EXL

Behaviour:
Register map (rd,sel): BadVAddr (8,0), Count (9,0), Compare (11,0), Status (12,0), Cause (13,0), EPC (14,0).
- Unmapped addresses read 0; writes to them are ignored.
- cp0_rdata is a pure function of current register state and cp0_addr; no read-during-write bypass.

Reset values (asynchronous, taken immediately on reset assertion):
- BadVAddr=0, Count=0, Compare=0, EPC=0, Cause=0, prescaler=0.
- Status=0x00400000 (BEV=1, IM=0, EXL=0, IE=0).
- Outputs at reset: int_pending=0, epc=0, status_exl=0.

Status fields:
- BEV bit22 read-only 1.
- IM[15:8], EXL bit1, IE bit0 are writable.
- All other bits read 0.

Cause fields:
- BD bit31 and TI bit30 are read-only.
- IP[15:10] are hardware-driven; IP[9:8] are software-writable.
- ExcCode[6:2] is read-only.
- All other bits read 0.

Hardware IP update, every cycle:
- IP[2+i] <= ext_int[i], giving 1-cycle latency.
- Bits without an ext_int line (i >= EXT_INT_NUM) read 0.
- IP[7] is ORed with TI.

Count prescaler:
- The prescaler counts 0..COUNT_DIV-1.
- Count increments by 1 (32-bit wrap, 0xFFFFFFFF->0) in the cycle the prescaler equals COUNT_DIV-1.
- COUNT_DIV=1 increments every cycle.
- An MTC0 write to Count loads cp0_wdata, clears the prescaler, and overrides that cycle's increment.

Timer interrupt (TI):
- TI is set in the cycle after Count increments to a value equal to Compare.
- A Count write does not set TI.
- An MTC0 write to Compare loads Compare and clears TI; the clear wins over a same-cycle set.
- Otherwise TI is sticky.

int_pending = IE & ~EXL & |(Cause.IP[7:0] & Status.IM[7:0]), combinational from registers.

Exception commit (exc_valid=1):
- If EXL=0 before the commit:
  - EPC <= exc_bd ? exc_pc-4 : exc_pc;
  - Cause.BD <= exc_bd.
- If EXL was already 1, EPC and BD are unchanged.
- Always:
  - ExcCode <= exc_code;
  - EXL <= 1;
  - BadVAddr <= exc_badvaddr only when exc_badv_valid=1.

ERET commit (eret=1 and exc_valid=0): EXL <= 0.

Priority and simultaneous events:
- exc_valid > eret > cp0_wen.
- When exc_valid or eret is high, cp0_wen is ignored, because the instruction is flushed.
- The Count/TI/IP hardware updates proceed regardless of these events.

Test Plan:
1. Assert reset mid-count -> all registers clear immediately; read Status=0x00400000, Count=0, int_pending=0.
2. COUNT_DIV=2; release reset; 10 cycles -> Count=5; MTC0 Count=0xFFFFFFFF, then 2 cycles -> Count=0 (wrap).
3. Compare=3, Status=0x00008001; Count reaches 3 -> next cycle Cause=0x40008000, int_pending=1; write Compare=10 -> TI=0, int_pending=0.
4. Exception exc_code=4, exc_pc=0xBFC00100, exc_bd=1, exc_badv_valid=1, exc_badvaddr=0x1234 -> EPC=0xBFC000FC, Cause=0x80000010, BadVAddr=0x1234, status_exl=1.
5. With EXL=1, second exception exc_pc=0x80000200, exc_bd=0, exc_code=8 -> EPC stays 0xBFC000FC, BD stays 1, ExcCode=8.
6. eret, exc_valid and cp0_wen(Status=0) in the same cycle -> EXL=1, exception fields updated, Status write dropped; ext_int[1]=1 -> Cause.IP3 set one cycle later.
